// File: rtl/mul_div_pkg.sv
// Shared encodings for the sequential signed multiply/divide unit.
package mul_div_pkg;

    localparam int DEF_DATA_WIDTH = 32;

    localparam logic OP_MUL = 1'b0;
    localparam logic OP_DIV = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CALC  = 2'd1,
        S_FIXUP = 2'd2,
        S_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/mul_div_step.sv
// One combinational iteration: radix-2 Booth step for multiply, restoring
// step on magnitudes for divide.
// Accumulator layout: {hi[W:0], lo[W-1:0], q1}
//   multiply: hi = partial product (one guard bit), lo = multiplier, q1 = Booth bit
//   divide:   hi = remainder, lo = dividend shifting out / quotient shifting in
module mul_div_step
    import mul_div_pkg::*;
#(
    parameter int W = DEF_DATA_WIDTH
) (
    input  logic           op,
    input  logic [2*W+1:0] acc,
    input  logic [W:0]     opnd,
    output logic [2*W+1:0] acc_next
);

    logic [W:0]   hi;
    logic [W:0]   hi_sum;
    logic [W:0]   rem_sh;
    logic [W:0]   diff;
    logic [W-1:0] lo;
    logic         q1;

    // Next accumulator for the selected operation
    always_comb begin
        hi       = acc[2*W+1:W+1];
        lo       = acc[W:1];
        q1       = acc[0];
        hi_sum   = hi;
        rem_sh   = '0;
        diff     = '0;
        acc_next = acc;
        if (op == OP_MUL) begin
            unique case ({lo[0], q1})
                2'b01:   hi_sum = hi + opnd;
                2'b10:   hi_sum = hi - opnd;
                default: hi_sum = hi;
            endcase
            // arithmetic shift right of {hi_sum, lo, q1}
            acc_next = {hi_sum[W], hi_sum, lo};
        end else begin
            rem_sh = {hi[W-1:0], lo[W-1]};
            diff   = rem_sh - opnd;
            // remainder stays below the divisor, so diff's MSB is a clean sign
            if (!diff[W])
                acc_next = {diff, lo[W-2:0], 1'b1, 1'b0};
            else
                acc_next = {rem_sh, lo[W-2:0], 1'b0, 1'b0};
        end
    end

endmodule

// File: rtl/mul_div_seq.sv
// Sequential signed multiply / divide: ITER iteration cycles, one fixup
// cycle for sign correction, one done cycle.
module mul_div_seq
    import mul_div_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ITER       = DATA_WIDTH
) (
    input  logic                  clock,
    input  logic                  clear,
    input  logic                  start,
    input  logic                  op,
    input  logic [DATA_WIDTH-1:0] A,
    input  logic [DATA_WIDTH-1:0] B,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] ZHigh,
    output logic [DATA_WIDTH-1:0] ZLow,
    output logic                  div_by_zero
);

    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(ITER + 1);

    state_t         state, state_nxt;
    logic [2*W+1:0] acc, acc_nxt;
    logic [W:0]     opnd;
    logic           op_q;
    logic [W-1:0]   a_q, b_q;
    logic [CW-1:0]  cnt;
    logic [W-1:0]   zhigh_q, zlow_q;
    logic           dbz_q;

    logic           accept;
    logic           last_iter;
    logic [W-1:0]   a_mag, b_mag;
    logic [W-1:0]   res_hi, res_lo;

    assign accept    = (state == S_IDLE) && start;
    assign last_iter = (cnt == CW'(ITER - 1));

    mul_div_step #(.W(W)) u_step (
        .op       (op_q),
        .acc      (acc),
        .opnd     (opnd),
        .acc_next (acc_nxt)
    );

    // Operand magnitudes for the restoring divider
    always_comb begin
        a_mag = A[W-1] ? (~A + 1'b1) : A;
        b_mag = B[W-1] ? (~B + 1'b1) : B;
    end

    // Sign correction / divide-by-zero override on the raw accumulator
    always_comb begin
        res_hi = acc[2*W:W+1];
        res_lo = acc[W:1];
        if (op_q == OP_DIV) begin
            if (b_q == '0) begin
                res_hi = a_q;
                res_lo = '1;
            end else begin
                if (a_q[W-1] ^ b_q[W-1]) res_lo = ~acc[W:1] + 1'b1;
                if (a_q[W-1])            res_hi = ~acc[2*W:W+1] + 1'b1;
            end
        end
    end

    // State register
    always_ff @(posedge clock) begin
        if (clear) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // Next-state: fixed IDLE -> CALC -> FIXUP -> DONE -> IDLE sequence
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:  if (start) state_nxt = S_CALC;
            S_CALC:  if (last_iter) state_nxt = S_FIXUP;
            S_FIXUP: state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Operand latch, iteration datapath and result registers
    always_ff @(posedge clock) begin
        if (clear) begin
            acc     <= '0;
            opnd    <= '0;
            op_q    <= OP_MUL;
            a_q     <= '0;
            b_q     <= '0;
            cnt     <= '0;
            zhigh_q <= '0;
            zlow_q  <= '0;
            dbz_q   <= 1'b0;
        end else begin
            if (accept) begin
                op_q  <= op;
                a_q   <= A;
                b_q   <= B;
                cnt   <= '0;
                dbz_q <= 1'b0;
                if (op == OP_MUL) begin
                    acc  <= {{(W+1){1'b0}}, B, 1'b0};
                    opnd <= {A[W-1], A};
                end else begin
                    acc  <= {{(W+1){1'b0}}, a_mag, 1'b0};
                    opnd <= {1'b0, b_mag};
                end
            end else if (state == S_CALC) begin
                acc <= acc_nxt;
                cnt <= cnt + 1'b1;
            end else if (state == S_FIXUP) begin
                zhigh_q <= res_hi;
                zlow_q  <= res_lo;
                dbz_q   <= (op_q == OP_DIV) && (b_q == '0);
            end
        end
    end

    assign busy        = (state == S_CALC) || (state == S_FIXUP);
    assign done        = (state == S_DONE);
    assign ZHigh       = zhigh_q;
    assign ZLow        = zlow_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_mul_div_seq.sv
// Directed bench for mul_div_seq at default 32-bit width.
module tb_mul_div_seq;

    logic        clock = 1'b0;
    logic        clear;
    logic        start;
    logic        op;
    logic [31:0] A, B;
    logic        busy, done, div_by_zero;
    logic [31:0] ZHigh, ZLow;

    int nvec = 0;
    int nerr = 0;

    mul_div_seq #(.DATA_WIDTH(32), .ITER(32)) dut (
        .clock       (clock),
        .clear       (clear),
        .start       (start),
        .op          (op),
        .A           (A),
        .B           (B),
        .busy        (busy),
        .done        (done),
        .ZHigh       (ZHigh),
        .ZLow        (ZLow),
        .div_by_zero (div_by_zero)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one operation, scramble inputs after acceptance, check latency and result
    task automatic run(input string tag, input logic o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] ehi, input logic [31:0] elo, input logic edbz);
        int lat;
        @(negedge clock);
        start = 1'b1; op = o; A = a; B = b;
        @(posedge clock); #1;
        start = 1'b0; A = $urandom; B = $urandom; op = ~o;
        chk({tag, ".busy_after_accept"}, 64'(busy), 64'd1);
        chk({tag, ".dbz_after_accept"}, 64'(div_by_zero), 64'd0);
        chk({tag, ".done_after_accept"}, 64'(done), 64'd0);
        lat = 0;
        while (done !== 1'b1 && lat < 100) begin
            @(posedge clock); #1;
            lat++;
        end
        chk({tag, ".latency"}, 64'(lat), 64'd33);
        chk({tag, ".ZHigh"}, 64'(ZHigh), 64'(ehi));
        chk({tag, ".ZLow"}, 64'(ZLow), 64'(elo));
        chk({tag, ".dbz"}, 64'(div_by_zero), 64'(edbz));
        @(posedge clock); #1;
        chk({tag, ".done_one_cycle"}, 64'(done), 64'd0);
        chk({tag, ".ZLow_held"}, 64'(ZLow), 64'(elo));
    endtask

    initial begin
        int ndone;
        logic [31:0] hold_hi, hold_lo;

        clear = 1'b1; start = 1'b0; op = 1'b0; A = '0; B = '0;
        repeat (2) @(posedge clock);
        #1;
        chk("reset.busy", 64'(busy), 64'd0);
        chk("reset.done", 64'(done), 64'd0);
        chk("reset.dbz", 64'(div_by_zero), 64'd0);
        chk("reset.ZHigh", 64'(ZHigh), 64'd0);
        chk("reset.ZLow", 64'(ZLow), 64'd0);
        @(negedge clock); clear = 1'b0;

        // 7 * -3 = -21
        run("mul_7_m3", 1'b0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
        // (-2^31)^2 = 2^62
        run("mul_min_min", 1'b0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0);
        // -1 * -1 = 1
        run("mul_m1_m1", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 1'b0);
        // -7 / 2 = -3 rem -1
        run("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        // 100 / -7 = -14 rem 2
        run("div_100_m7", 1'b1, 32'd100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFF2, 1'b0);
        // 5 / 0
        run("div_5_0", 1'b1, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 1'b1);
        // -2^31 / -1 wraps to -2^31, no error (also checks dbz cleared on accept)
        run("div_min_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0);

        // start held high through the operation while A keeps changing: 3 * 5
        @(negedge clock);
        start = 1'b1; op = 1'b0; A = 32'd3; B = 32'd5;
        ndone = 0; hold_hi = 32'hDEAD_BEEF; hold_lo = 32'hDEAD_BEEF;
        for (int i = 0; i < 60; i++) begin
            @(posedge clock); #1;
            if (done === 1'b1) begin
                ndone++;
                hold_hi = ZHigh;
                hold_lo = ZLow;
                start = 1'b0;
            end
            @(negedge clock);
            A = $urandom;
        end
        start = 1'b0;
        chk("hold_start.done_count", 64'(ndone), 64'd1);
        chk("hold_start.ZHigh", 64'(hold_hi), 64'd0);
        chk("hold_start.ZLow", 64'(hold_lo), 64'd15);

        // clear partway through CALC aborts without a done pulse
        @(negedge clock);
        start = 1'b1; op = 1'b0; A = 32'd9; B = 32'd9;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (10) @(posedge clock);
        @(negedge clock); clear = 1'b1;
        @(posedge clock); #1;
        chk("abort.busy", 64'(busy), 64'd0);
        chk("abort.done", 64'(done), 64'd0);
        chk("abort.ZHigh", 64'(ZHigh), 64'd0);
        chk("abort.ZLow", 64'(ZLow), 64'd0);
        @(negedge clock); clear = 1'b0;
        ndone = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clock); #1;
            if (done === 1'b1) ndone++;
        end
        chk("abort.no_done", 64'(ndone), 64'd0);
        run("after_abort", 1'b0, 32'd9, 32'hFFFF_FFF7, 32'hFFFF_FFFF, 32'hFFFF_FFAF, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/mul_div_seq.md
MUL_DIV_SEQ -- requirements
Module: mul_div_seq

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, operand and result-half width.
REQ-002 SHALL have parameter ITER, default DATA_WIDTH, iteration count per operation.
REQ-003 SHALL have port clock  input  1  the single clock; all state updates on posedge clock.
REQ-004 SHALL have port clear  input  1  reset; synchronous, active-high.
REQ-005 SHALL have port start  input  1  request; sampled only in IDLE.
REQ-006 SHALL have port op  input  1  0 = signed multiply, 1 = signed divide.
REQ-007 SHALL have port A  input  DATA_WIDTH  multiplicand or dividend.
REQ-008 SHALL have port B  input  DATA_WIDTH  multiplier or divisor.
REQ-009 SHALL have port busy  output  1  high from the cycle after start acceptance until done.
REQ-010 SHALL have port done  output  1  one-cycle pulse when results are valid.
REQ-011 SHALL have port ZHigh  output  DATA_WIDTH  product upper half or remainder; feeds the Z-high register.
REQ-012 SHALL have port ZLow  output  DATA_WIDTH  product lower half or quotient; feeds the Z-low register.
REQ-013 SHALL have port div_by_zero  output  1  set with done when op=1 and B=0.

Function
REQ-014 SHALL implement states IDLE, CALC, FIXUP, DONE.
REQ-015 SHALL, in IDLE with start=1, latch A, B and op, clear the iteration counter, and enter CALC.
REQ-016 SHALL execute one radix-2 Booth step (multiply) or one restoring step on magnitudes (divide) per CALC cycle, for exactly ITER cycles.
REQ-017 SHALL go from CALC to FIXUP after iteration ITER-1, then to DONE, then to IDLE, with no other transitions.
REQ-018 SHALL apply sign correction in FIXUP for divide, and pass the result through unchanged for multiply; latency is identical for both ops.
REQ-019 SHALL, when start is sampled in cycle 0, assert done in cycle ITER+2, which is cycle 34 at the default parameters.
REQ-020 SHALL update ZHigh and ZLow only on entry to DONE, and hold them until the next completed operation or clear.
REQ-021 SHALL produce the full 2*DATA_WIDTH-bit two's-complement product for multiply.
REQ-022 SHALL, for divide, truncate the quotient toward zero and give the remainder the sign of the dividend.
REQ-023 SHALL return quotient 0x80000000 and remainder 0 for divide -2^31 / -1, with no error flag.
REQ-024 SHALL, for divide with B=0, return ZLow=all-ones, ZHigh=A and div_by_zero=1 after the normal latency.
REQ-025 SHALL clear div_by_zero when the next operation is accepted.
REQ-026 SHALL ignore start while in CALC, FIXUP or DONE; inputs A, B and op may change freely after acceptance.
REQ-027 SHALL NOT accept start in DONE; a new start is accepted no earlier than the cycle after done.

Reset
REQ-028 SHALL, when clear=1 at a clock edge, enter IDLE and set busy=0, done=0, div_by_zero=0, ZHigh=0, ZLow=0.
REQ-029 SHALL give clear priority over start and over every state, so clear mid-operation aborts with no done pulse.
REQ-030 SHALL have the same values from an initial block as from clear, for simulation.

Structure
REQ-031 SHALL place the state encoding, the op encodings (OP_MUL=0, OP_DIV=1) and the DATA_WIDTH default in a shared package mul_div_pkg.
REQ-032 SHALL use one sub-module, mul_div_step: a combinational single iteration that takes the accumulator, operand and op and returns the next accumulator.
REQ-033 SHALL be scoped at 120-400 lines of RTL with no vendor primitives.

Verification
REQ-034 SHALL cover: mul A=7, B=0xFFFFFFFD -> ZHigh=0xFFFFFFFF, ZLow=0xFFFFFFEB, done at cycle 34.
REQ-035 SHALL cover: mul A=B=0x80000000 -> ZHigh=0x40000000, ZLow=0x00000000.
REQ-036 SHALL cover: div A=0xFFFFFFF9 (-7), B=2 -> ZLow=0xFFFFFFFD, ZHigh=0xFFFFFFFF, div_by_zero=0.
REQ-037 SHALL cover: div A=5, B=0 -> ZLow=0xFFFFFFFF, ZHigh=0x00000005, div_by_zero=1 with done.
REQ-038 SHALL cover: start held high through CALC with changing A -> exactly one done pulse, and the result uses the A value latched at acceptance.
REQ-039 SHALL cover: clear at CALC iteration 10 -> next cycle busy=0, ZHigh=ZLow=0, no done pulse; a following start completes normally.
